// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial run-length detector.
// Imported by the top level and by the run-length counter.
package seq_det_pkg;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  localparam int DEF_RUN_LEN = 4;
  localparam int DEF_EVT_W   = 16;

  // Number of bits needed to encode values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/run_len_counter.sv
// Tracks the value and saturating length of the current run of equal bits,
// exposing the next-state values and a strobe when the run reaches RUN_LEN.
module run_len_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W   = 3,
  parameter int RUN_LEN = DEF_RUN_LEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  input  logic             in_i,
  output logic             run_bit_o,
  output logic [CNT_W-1:0] run_len_o,
  output logic             run_bit_next_o,
  output logic [CNT_W-1:0] run_len_next_o,
  output logic             reach_max_o
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] LEN_PRE = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

  logic             run_bit_q;
  logic             run_bit_d;
  logic [CNT_W-1:0] run_len_q;
  logic [CNT_W-1:0] run_len_d;
  logic             have_bit_q;
  logic             have_bit_d;
  logic             extend_s;

  always_comb begin
    run_bit_d  = run_bit_q;
    run_len_d  = run_len_q;
    have_bit_d = have_bit_q;
    extend_s   = 1'b0;
    if (clear_i) begin
      run_bit_d  = 1'b0;
      run_len_d  = '0;
      have_bit_d = 1'b0;
    end else if (in_valid_i) begin
      if (have_bit_q && (in_i == run_bit_q)) begin
        extend_s = 1'b1;
        if (run_len_q != LEN_MAX) begin
          run_len_d = run_len_q + LEN_ONE;
        end else begin
          run_len_d = LEN_MAX;
        end
      end else begin
        run_bit_d  = in_i;
        run_len_d  = LEN_ONE;
        have_bit_d = 1'b1;
      end
    end else begin
      run_bit_d  = run_bit_q;
      run_len_d  = run_len_q;
      have_bit_d = have_bit_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_bit_q  <= 1'b0;
      run_len_q  <= '0;
      have_bit_q <= 1'b0;
    end else begin
      run_bit_q  <= run_bit_d;
      run_len_q  <= run_len_d;
      have_bit_q <= have_bit_d;
    end
  end

  // Only the RUN_LEN-1 -> RUN_LEN step counts; a saturated run stays quiet.
  assign reach_max_o    = extend_s && (run_len_q == LEN_PRE);
  assign run_bit_o      = run_bit_q;
  assign run_len_o      = run_len_q;
  assign run_bit_next_o = run_bit_d;
  assign run_len_next_o = run_len_d;

endmodule

// File: rtl/seq_run_detector.sv
// Parametrised detector flagging RUN_LEN consecutive equal serial bits,
// with per-polarity enables, level/pulse output and a saturating event count.
module seq_run_detector
  import seq_det_pkg::*;
#(
  parameter  int RUN_LEN = DEF_RUN_LEN,
  parameter  int EVT_W   = DEF_EVT_W,
  localparam int CNT_W   = clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in,
  input  logic             det_zero_en,
  input  logic             det_one_en,
  input  logic             pulse_mode,
  output logic             out,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_len,
  output logic [EVT_W-1:0] evt_count
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(RUN_LEN);
  localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};
  localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);

  logic             run_bit_next_s;
  logic [CNT_W-1:0] run_len_next_s;
  logic             reach_max_s;
  logic             en_next_s;
  logic             event_s;
  logic             out_q;
  logic             out_d;
  logic [EVT_W-1:0] evt_q;
  logic [EVT_W-1:0] evt_d;

  function automatic logic bit_enabled(input logic b, input logic zero_en, input logic one_en);
    return b ? one_en : zero_en;
  endfunction

  run_len_counter #(
    .CNT_W   (CNT_W),
    .RUN_LEN (RUN_LEN)
  ) u_run_len_counter (
    .clk_i          (clk),
    .rst_i          (reset),
    .clear_i        (clear),
    .in_valid_i     (in_valid),
    .in_i           (in),
    .run_bit_o      (run_bit),
    .run_len_o      (run_len),
    .run_bit_next_o (run_bit_next_s),
    .run_len_next_o (run_len_next_s),
    .reach_max_o    (reach_max_s)
  );

  always_comb begin
    en_next_s = bit_enabled(run_bit_next_s, det_zero_en, det_one_en);
    event_s   = reach_max_s && en_next_s;
    out_d     = 1'b0;
    evt_d     = evt_q;
    if (clear) begin
      out_d = 1'b0;
      evt_d = '0;
    end else begin
      if (pulse_mode == MODE_PULSE) begin
        out_d = event_s;
      end else begin
        out_d = (run_len_next_s == LEN_MAX) && en_next_s;
      end
      if (event_s && (evt_q != EVT_MAX)) begin
        evt_d = evt_q + EVT_ONE;
      end else begin
        evt_d = evt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= 1'b0;
      evt_q <= '0;
    end else begin
      out_q <= out_d;
      evt_q <= evt_d;
    end
  end

  assign out       = out_q;
  assign evt_count = evt_q;

endmodule

// File: tb/tb_seq_run_detector.sv
// Scoreboard bench for seq_run_detector: a driver pushes expected state from a
// history-based reference model, a monitor pops and compares after each edge.
module tb_seq_run_detector;

  localparam int RUN_LEN = 4;
  localparam int EVT_W   = 3;
  localparam int CNT_W   = 3;
  localparam int EVT_MAX = (1 << EVT_W) - 1;

  typedef struct packed {
    logic             o;
    logic             rb;
    logic [CNT_W-1:0] rl;
    logic [EVT_W-1:0] ev;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             det_zero_en = 1'b1;
  logic             det_one_en = 1'b1;
  logic             pulse_mode = 1'b0;
  logic             out_s;
  logic             run_bit_s;
  logic [CNT_W-1:0] run_len_s;
  logic [EVT_W-1:0] evt_s;

  int   total = 0;
  int   bad = 0;
  exp_t expq[$];
  exp_t mon_e;

  bit   hist[$];
  int   m_evt = 0;
  bit   m_out = 1'b0;
  bit   ze = 1'b1;
  bit   oe = 1'b1;
  bit   pm = 1'b0;

  seq_run_detector #(
    .RUN_LEN (RUN_LEN),
    .EVT_W   (EVT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in          (in_bit),
    .det_zero_en (det_zero_en),
    .det_one_en  (det_one_en),
    .pulse_mode  (pulse_mode),
    .out         (out_s),
    .run_bit     (run_bit_s),
    .run_len     (run_len_s),
    .evt_count   (evt_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Number of identical bits at the tail of the recorded stream.
  function automatic int trail();
    int n;
    n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  function automatic bit enabled_for(input bit b);
    return b ? oe : ze;
  endfunction

  function automatic exp_t model_edge(input bit rst, input bit clr, input bit v, input bit b);
    exp_t e;
    bit   ev;
    int   rl;
    bit   rb;
    ev = 1'b0;
    if (rst || clr) begin
      hist.delete();
      m_evt = 0;
      m_out = 1'b0;
    end else begin
      if (v) begin
        hist.push_back(b);
        if (hist.size() > RUN_LEN + 1) void'(hist.pop_front());
        if (trail() == RUN_LEN && enabled_for(b)) ev = 1'b1;
      end
      if (ev && m_evt < EVT_MAX) m_evt++;
      rl = (trail() > RUN_LEN) ? RUN_LEN : trail();
      rb = (hist.size() > 0) ? hist[hist.size() - 1] : 1'b0;
      m_out = pm ? ev : ((rl == RUN_LEN) && enabled_for(rb));
    end
    rl = (trail() > RUN_LEN) ? RUN_LEN : trail();
    e.o  = m_out;
    e.rb = (hist.size() > 0) ? hist[hist.size() - 1] : 1'b0;
    e.rl = CNT_W'(rl);
    e.ev = EVT_W'(m_evt);
    return e;
  endfunction

  task automatic step(input bit rst, input bit clr, input bit v, input bit b);
    @(negedge clk);
    reset       = rst;
    clear       = clr;
    in_valid    = v;
    in_bit      = b;
    det_zero_en = ze;
    det_one_en  = oe;
    pulse_mode  = pm;
    expq.push_back(model_edge(rst, clr, v, b));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge with a pending expectation is compared.
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      chk("out", int'(out_s), int'(mon_e.o));
      chk("run_bit", int'(run_bit_s), int'(mon_e.rb));
      chk("run_len", int'(run_len_s), int'(mon_e.rl));
      chk("evt_count", int'(evt_s), int'(mon_e.ev));
    end
  end

  initial begin
    bit prev_b;
    bit rb;
    repeat (2) @(negedge clk);
    chk("reset_out", int'(out_s), 0);
    chk("reset_run_len", int'(run_len_s), 0);
    chk("reset_evt", int'(evt_s), 0);

    // Five zeros in level mode.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("zeros_out", int'(out_s), 1);
    chk("zeros_run_len", int'(run_len_s), 4);
    chk("zeros_evt", int'(evt_s), 1);

    // Level: 1111 0 1111.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, (i == 4) ? 1'b0 : 1'b1);
    settle();
    chk("level_out", int'(out_s), 1);
    chk("level_evt", int'(evt_s), 2);

    // Pulse mode: seven ones with a two-cycle gap mid-run.
    pm = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("pulse_out", int'(out_s), 0);
    chk("pulse_run_len", int'(run_len_s), 4);
    chk("pulse_evt", int'(evt_s), 1);

    // Zero detection disabled: six zeros then four ones.
    pm = 1'b0;
    ze = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, (i < 6) ? 1'b0 : 1'b1);
    settle();
    chk("zdis_out", int'(out_s), 1);
    chk("zdis_evt", int'(evt_s), 1);
    ze = 1'b1;

    // Asynchronous reset between edges.
    @(negedge clk);
    reset = 1'b1;
    expq.push_back(model_edge(1'b1, 1'b0, 1'b0, 1'b0));
    #1;
    chk("async_out", int'(out_s), 0);
    chk("async_run_len", int'(run_len_s), 0);
    chk("async_evt", int'(evt_s), 0);

    // Eight alternating runs of four saturate the 3-bit event counter.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, r[0]);
    settle();
    chk("sat_evt", int'(evt_s), EVT_MAX);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    settle();
    chk("clear_out", int'(out_s), 0);
    chk("clear_run_len", int'(run_len_s), 0);
    chk("clear_evt", int'(evt_s), 0);

    // Randomised traffic with run-friendly bit bias.
    prev_b = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) < 3) ze = ~ze;
      if ($urandom_range(99) < 3) oe = ~oe;
      if ($urandom_range(99) < 4) pm = ~pm;
      rb = ($urandom_range(99) < 75) ? prev_b : ~prev_b;
      prev_b = rb;
      step(($urandom_range(199) == 0), ($urandom_range(99) < 2),
           ($urandom_range(99) < 80), rb);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
